// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory-side request/response bus between the
// instruction cache (port 0) and the data cache (port 1). A round-robin
// grant picks one owner, its address/tag are latched, and the owner keeps
// the bus until all BEATS response beats have been handshaken. Ack and beat
// paths are pure combinational pass-through so no latency is added per beat.
module mem_bus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      p0_bus_reqcyc,
    output logic                      p0_bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] p0_bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  p0_bus_reqtag,
    output logic                      p0_bus_respcyc,
    input  logic                      p0_bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] p0_bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  p0_bus_resptag,

    input  logic                      p1_bus_reqcyc,
    output logic                      p1_bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] p1_bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  p1_bus_reqtag,
    output logic                      p1_bus_respcyc,
    input  logic                      p1_bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] p1_bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  p1_bus_resptag,

    output logic                      m_bus_reqcyc,
    input  logic                      m_bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] m_bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
    input  logic                      m_bus_respcyc,
    output logic                      m_bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] m_bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag
);

    // A single-beat configuration still needs a one-bit counter.
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic                      owner_q, owner_d;
    logic                      last_q,  last_d;
    logic [BUS_DATA_WIDTH-1:0] req_q,   req_d;
    logic [BUS_TAG_WIDTH-1:0]  tag_q,   tag_d;
    logic [BEAT_W-1:0]         beat_q,  beat_d;

    logic                      own_respack_s;
    logic                      beat_done_s;
    logic                      winner_s;

    assign own_respack_s = owner_q ? p1_bus_respack : p0_bus_respack;
    assign beat_done_s   = m_bus_respcyc & own_respack_s;
    // With both requesting, the port that was not served last wins.
    assign winner_s      = (p0_bus_reqcyc & p1_bus_reqcyc) ? ~last_q : p1_bus_reqcyc;

    // State registers; reset==0 at a clock edge abandons any transaction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            req_q   <= '0;
            tag_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            req_q   <= req_d;
            tag_q   <= tag_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state: grant in IDLE, wait for ack in REQ, count beats in RESP.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        req_d   = req_q;
        tag_d   = tag_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (p0_bus_reqcyc | p1_bus_reqcyc) begin
                    owner_d = winner_s;
                    req_d   = winner_s ? p1_bus_req    : p0_bus_req;
                    tag_d   = winner_s ? p1_bus_reqtag : p0_bus_reqtag;
                    beat_d  = '0;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (m_bus_reqack) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_RESP: begin
                if (beat_done_s) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        last_d  = owner_q;
                        state_d = ST_IDLE;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Output steering: only the owner sees ack/beats; everything else is 0.
    always_comb begin
        p0_bus_reqack  = 1'b0;
        p0_bus_respcyc = 1'b0;
        p0_bus_resp    = '0;
        p0_bus_resptag = '0;
        p1_bus_reqack  = 1'b0;
        p1_bus_respcyc = 1'b0;
        p1_bus_resp    = '0;
        p1_bus_resptag = '0;
        m_bus_reqcyc   = 1'b0;
        m_bus_req      = '0;
        m_bus_reqtag   = '0;
        m_bus_respack  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                m_bus_reqcyc = 1'b0;
            end
            ST_REQ: begin
                m_bus_reqcyc = 1'b1;
                m_bus_req    = req_q;
                m_bus_reqtag = tag_q;
                if (owner_q) begin
                    p1_bus_reqack = m_bus_reqack;
                end else begin
                    p0_bus_reqack = m_bus_reqack;
                end
            end
            ST_RESP: begin
                m_bus_respack = own_respack_s;
                if (owner_q) begin
                    p1_bus_respcyc = m_bus_respcyc;
                    p1_bus_resp    = m_bus_resp;
                    p1_bus_resptag = m_bus_resptag;
                end else begin
                    p0_bus_respcyc = m_bus_respcyc;
                    p0_bus_resp    = m_bus_resp;
                    p0_bus_resptag = m_bus_resptag;
                end
            end
            default: begin
                m_bus_reqcyc = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: the bench plays the memory side and
// both caches, with expected addresses, beats and grant order written in.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_bus_reqcyc, p0_bus_reqack, p0_bus_respcyc, p0_bus_respack;
    logic [63:0] p0_bus_req, p0_bus_resp;
    logic [12:0] p0_bus_reqtag, p0_bus_resptag;
    logic        p1_bus_reqcyc, p1_bus_reqack, p1_bus_respcyc, p1_bus_respack;
    logic [63:0] p1_bus_req, p1_bus_resp;
    logic [12:0] p1_bus_reqtag, p1_bus_resptag;
    logic        m_bus_reqcyc, m_bus_reqack, m_bus_respcyc, m_bus_respack;
    logic [63:0] m_bus_req, m_bus_resp;
    logic [12:0] m_bus_reqtag, m_bus_resptag;

    int n_cmp = 0;
    int n_err = 0;

    mem_bus_arbiter #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .BEATS(8)) dut (
        .clk(clk), .reset(reset),
        .p0_bus_reqcyc(p0_bus_reqcyc), .p0_bus_reqack(p0_bus_reqack),
        .p0_bus_req(p0_bus_req), .p0_bus_reqtag(p0_bus_reqtag),
        .p0_bus_respcyc(p0_bus_respcyc), .p0_bus_respack(p0_bus_respack),
        .p0_bus_resp(p0_bus_resp), .p0_bus_resptag(p0_bus_resptag),
        .p1_bus_reqcyc(p1_bus_reqcyc), .p1_bus_reqack(p1_bus_reqack),
        .p1_bus_req(p1_bus_req), .p1_bus_reqtag(p1_bus_reqtag),
        .p1_bus_respcyc(p1_bus_respcyc), .p1_bus_respack(p1_bus_respack),
        .p1_bus_resp(p1_bus_resp), .p1_bus_resptag(p1_bus_resptag),
        .m_bus_reqcyc(m_bus_reqcyc), .m_bus_reqack(m_bus_reqack),
        .m_bus_req(m_bus_req), .m_bus_reqtag(m_bus_reqtag),
        .m_bus_respcyc(m_bus_respcyc), .m_bus_respack(m_bus_respack),
        .m_bus_resp(m_bus_resp), .m_bus_resptag(m_bus_resptag)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Entered at the negedge of the first REQ cycle. Acks after ack_dly
    // cycles, then returns beats base+i with tag tg. With stall set, memory
    // inserts respcyc gaps and the owner withholds respack for 3 cycles.
    // abort_at < 8 returns early at the negedge after that many beats.
    task automatic serve(input int port, input logic [63:0] addr, input logic [12:0] tg,
                         input logic [63:0] base, input int ack_dly, input bit stall,
                         input int abort_at);
        int   beat;
        int   cyc;
        logic rc;
        logic ra;
        for (int i = 0; i < ack_dly; i++) begin
            #1;
            check_eq("req_cyc", m_bus_reqcyc, 64'd1);
            check_eq("req_addr", m_bus_req, addr);
            check_eq("req_tag", m_bus_reqtag, 64'(tg));
            check_eq("ack_early", 64'(p0_bus_reqack | p1_bus_reqack), 64'd0);
            @(negedge clk);
        end
        m_bus_reqack = 1'b1;
        #1;
        check_eq("req_addr_ack", m_bus_req, addr);
        check_eq("own_reqack", port ? p1_bus_reqack : p0_bus_reqack, 64'd1);
        check_eq("oth_reqack", port ? p0_bus_reqack : p1_bus_reqack, 64'd0);
        @(negedge clk);
        m_bus_reqack = 1'b0;
        beat = 0;
        cyc  = 0;
        while (beat < abort_at && cyc < 200) begin
            rc = stall ? ((cyc % 3) != 1) : 1'b1;
            ra = stall ? !(cyc >= 4 && cyc < 7) : 1'b1;
            m_bus_respcyc  = rc;
            m_bus_resp     = base + 64'(beat);
            m_bus_resptag  = tg;
            p0_bus_respack = port ? 1'b1 : ra;
            p1_bus_respack = port ? ra : 1'b1;
            #1;
            check_eq("own_respcyc", port ? p1_bus_respcyc : p0_bus_respcyc, 64'(rc));
            check_eq("own_resp", port ? p1_bus_resp : p0_bus_resp, base + 64'(beat));
            check_eq("own_resptag", port ? p1_bus_resptag : p0_bus_resptag, 64'(tg));
            check_eq("m_respack", m_bus_respack, 64'(ra));
            check_eq("oth_respcyc", port ? p0_bus_respcyc : p1_bus_respcyc, 64'd0);
            check_eq("oth_resp", port ? p0_bus_resp : p1_bus_resp, 64'd0);
            check_eq("oth_reqack", port ? p0_bus_reqack : p1_bus_reqack, 64'd0);
            check_eq("m_reqcyc_resp", m_bus_reqcyc, 64'd0);
            if (rc && ra) beat++;
            cyc++;
            @(negedge clk);
        end
        if (abort_at >= 8) begin
            check_eq("burst_len", 64'(beat), 64'd8);
            m_bus_respcyc  = 1'b1;
            p0_bus_respack = 1'b1;
            p1_bus_respack = 1'b1;
            #1;
            check_eq("idle_respcyc", 64'(p0_bus_respcyc | p1_bus_respcyc), 64'd0);
            check_eq("idle_reqcyc", m_bus_reqcyc, 64'd0);
            check_eq("idle_respack", m_bus_respack, 64'd0);
            m_bus_respcyc  = 1'b0;
            p0_bus_respack = 1'b0;
            p1_bus_respack = 1'b0;
            m_bus_resp     = 64'd0;
        end
    endtask

    initial begin
        reset = 1'b0;
        p0_bus_reqcyc = 1'b0; p0_bus_req = 64'd0; p0_bus_reqtag = 13'd0; p0_bus_respack = 1'b0;
        p1_bus_reqcyc = 1'b0; p1_bus_req = 64'd0; p1_bus_reqtag = 13'd0; p1_bus_respack = 1'b0;
        m_bus_reqack = 1'b0; m_bus_respcyc = 1'b0; m_bus_resp = 64'd0; m_bus_resptag = 13'd0;

        // Reset state: all outputs 0.
        @(negedge clk);
        #1;
        check_eq("rst_reqcyc", m_bus_reqcyc, 64'd0);
        check_eq("rst_reqacks", 64'(p0_bus_reqack | p1_bus_reqack), 64'd0);
        check_eq("rst_respack", m_bus_respack, 64'd0);
        check_eq("rst_m_req", m_bus_req, 64'd0);

        // Single p0 request, ack after 2 cycles, beats 0xA0..0xA7.
        @(negedge clk);
        reset = 1'b1;
        p0_bus_reqcyc = 1'b1; p0_bus_req = 64'h1000; p0_bus_reqtag = 13'h5;
        @(negedge clk);
        p0_bus_reqcyc = 1'b0;
        serve(0, 64'h1000, 13'h5, 64'hA0, 2, 1'b0, 8);

        // Owner changes address after grant: latched value stays on the bus.
        @(negedge clk);
        p0_bus_reqcyc = 1'b1; p0_bus_req = 64'h2000; p0_bus_reqtag = 13'h7;
        @(negedge clk);
        p0_bus_reqcyc = 1'b0; p0_bus_req = 64'hDEAD; p0_bus_reqtag = 13'h1F;
        serve(0, 64'h2000, 13'h7, 64'hB0, 3, 1'b0, 8);

        // Both requesting from reset: grants alternate 0,1,0,1.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        p0_bus_reqcyc = 1'b1; p0_bus_req = 64'h100; p0_bus_reqtag = 13'h10;
        p1_bus_reqcyc = 1'b1; p1_bus_req = 64'h200; p1_bus_reqtag = 13'h11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 3) begin
                p0_bus_reqcyc = 1'b0;
                p1_bus_reqcyc = 1'b0;
            end
            if ((k % 2) == 0) serve(0, 64'h100, 13'h10, 64'h1000 + 64'(k * 16), 1, 1'b0, 8);
            else              serve(1, 64'h200, 13'h11, 64'h1000 + 64'(k * 16), 1, 1'b0, 8);
        end

        // p1 owner with stalled memory and withheld respack.
        @(negedge clk);
        p1_bus_reqcyc = 1'b1; p1_bus_req = 64'h3300; p1_bus_reqtag = 13'h33;
        @(negedge clk);
        p1_bus_reqcyc = 1'b0;
        serve(1, 64'h3300, 13'h33, 64'hC0, 0, 1'b1, 8);

        // p1 requests during a p0 burst: waits, then granted after IDLE cycle.
        @(negedge clk);
        p0_bus_reqcyc = 1'b1; p0_bus_req = 64'h3000; p0_bus_reqtag = 13'h3;
        @(negedge clk);
        p0_bus_reqcyc = 1'b0;
        p1_bus_reqcyc = 1'b1; p1_bus_req = 64'h4000; p1_bus_reqtag = 13'h4;
        serve(0, 64'h3000, 13'h3, 64'hD0, 1, 1'b0, 8);
        @(negedge clk);
        p1_bus_reqcyc = 1'b0;
        serve(1, 64'h4000, 13'h4, 64'hE0, 1, 1'b0, 8);

        // Reset at beat 4 of a p0 burst, then a fresh p1 transaction.
        @(negedge clk);
        p0_bus_reqcyc = 1'b1; p0_bus_req = 64'h5000; p0_bus_reqtag = 13'h9;
        @(negedge clk);
        p0_bus_reqcyc = 1'b0;
        serve(0, 64'h5000, 13'h9, 64'hF0, 0, 1'b0, 4);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check_eq("rstmid_respcyc", 64'(p0_bus_respcyc | p1_bus_respcyc), 64'd0);
        check_eq("rstmid_resp", p0_bus_resp, 64'd0);
        check_eq("rstmid_respack", m_bus_respack, 64'd0);
        check_eq("rstmid_reqcyc", m_bus_reqcyc, 64'd0);
        reset = 1'b1;
        m_bus_respcyc = 1'b0; p0_bus_respack = 1'b0; p1_bus_respack = 1'b0;
        p1_bus_reqcyc = 1'b1; p1_bus_req = 64'h6000; p1_bus_reqtag = 13'h6;
        @(negedge clk);
        p1_bus_reqcyc = 1'b0;
        serve(1, 64'h6000, 13'h6, 64'h60, 1, 1'b0, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter that shares the single DRAM-side system bus between the instruction cache (port 0) and the data cache (port 1). Each cache presents the same request/response handshake it would use toward memory. The arbiter grants one owner at a time using round-robin priority, then forwards that owner's request and its full multi-beat response burst. It holds the grant until the burst completes. It sits between the two cache controllers and the Sysbus memory interface.

## Interface
- BUS_DATA_WIDTH, 64, address and data width
- BUS_TAG_WIDTH, 13, request/response tag width
- BEATS, 8, response beats per transaction (cache line = BEATS × BUS_DATA_WIDTH)

Ports:
- clk  in  1  single clock; all state changes on posedge
- reset  in  1  synchronous, active-low reset (reset==0 at posedge resets)
- p0_bus_reqcyc / p1_bus_reqcyc  in  1  requester wants the bus
- p0_bus_reqack / p1_bus_reqack  out  1  request accepted by memory
- p0_bus_req / p1_bus_req  in  BUS_DATA_WIDTH  request address
- p0_bus_reqtag / p1_bus_reqtag  in  BUS_TAG_WIDTH  request tag
- p0_bus_respcyc / p1_bus_respcyc  out  1  response beat valid
- p0_bus_respack / p1_bus_respack  in  1  requester accepts beat
- p0_bus_resp / p1_bus_resp  out  BUS_DATA_WIDTH  response data
- p0_bus_resptag / p1_bus_resptag  out  BUS_TAG_WIDTH  response tag
- m_bus_reqcyc  out  1; m_bus_reqack  in  1
- m_bus_req  out  BUS_DATA_WIDTH; m_bus_reqtag  out  BUS_TAG_WIDTH
- m_bus_respcyc  in  1; m_bus_respack  out  1
- m_bus_resp  in  BUS_DATA_WIDTH; m_bus_resptag  in  BUS_TAG_WIDTH

## Operation
- States: IDLE, REQ, RESP. Registers: state, owner (1 bit), last (1 bit, last-served port), req_q/tag_q (latched address/tag), beat (log2(BEATS) bits, plus a done compare).
- IDLE: drive no outputs. If exactly one pX_bus_reqcyc is 1, that port wins. If both are 1, the port ≠ last wins. On a win: owner←winner, req_q/tag_q←winner's req/reqtag, beat←0, →REQ.
- REQ: m_bus_reqcyc=1, m_bus_req=req_q, m_bus_reqtag=tag_q. p[owner]_bus_reqack = m_bus_reqack (combinational, same cycle). On m_bus_reqack=1 →RESP; otherwise stay.
- RESP: p[owner]_bus_respcyc = m_bus_respcyc; p[owner]_bus_resp/resptag = m_bus_resp/resptag; m_bus_respack = p[owner]_bus_respack.
  - A beat completes on a cycle with m_bus_respcyc & p[owner]_bus_respack; beat←beat+1.
  - On the BEATS-th completed beat: last←owner, →IDLE.
  - No tag checking; tags pass through unchanged.
- Non-owner port: reqack, respcyc, resp and resptag held at 0 at all times. A pending request from the non-owner waits; it is never dropped.
- Latched address: once granted, deassertion or change of the owner's reqcyc/req does not affect m_bus_req.

## Timing
- Reset values: state=IDLE, last=1 (port 0 wins the first tie), owner=0, beat=0. All outputs 0.
- Reset mid-transaction (any state) returns to IDLE next edge with all outputs 0. A partially delivered burst is abandoned.
- Grant latency: reqcyc seen in IDLE at edge N puts m_bus_reqcyc=1 in cycle N+1.
- Ack is zero-latency pass-through. RESP is entered the cycle after m_bus_reqack.
- Beat forwarding is combinational in both directions, with zero added latency per beat. Stall cycles (respcyc=0 or respack=0) do not count.
- Last beat at edge K gives IDLE in K+1. The next grant is decided in K+1, and the next m_bus_reqcyc is asserted in K+2. The minimum gap between transactions is 1 idle cycle.
- Beat counter wraps to 0 on return to IDLE. A BEATS that is a power of two needs no special case.
- Simultaneous requests under continuous demand alternate 0,1,0,1… Neither port waits more than one transaction.

## Test plan
- Single p0 request to 0x1000, tag 0x5. Memory acks after 2 cycles and returns 8 beats 0xA0..0xA7 → m_bus_req=0x1000, p0 gets 8 beats in order with tag 0x5, p1 outputs stay 0, back to IDLE.
- Both ports request from reset with continuous demand → grant order p0, p1, p0, p1. last toggles after each 8th beat.
- p1 owns the bus and the memory response stalls (respcyc gaps, p1 respack withheld 3 cycles) → beat count advances only on handshake cycles, exactly 8 beats delivered, no duplicates.
- Owner drops reqcyc and changes address to 0xDEAD after grant, before ack → m_bus_req stays at the latched value until ack.
- Assert reset (reset=0) at beat 4 of a p0 burst → next cycle: IDLE, all outputs 0, beat=0, last=1. A new p1 request is granted cleanly after reset is released.
- p1 requests during an active p0 burst → p1_bus_reqack stays 0 until the p0 burst ends. p1 is granted in the IDLE cycle after the p0 burst, and m_bus_reqcyc is asserted the cycle after that.
